burst_mem_slave: RTL

BURST_MEM_SLAVE -- requirements
Module: burst_mem_slave

---
 rtl/burst_mem_slave.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/burst_mem_slave.sv
// Burst memory slave: a word-addressed RAM behind a multiplexed address/data
// bus. Write bursts honour per-byte lane enables and optional periodic busy
// stalls. Read bursts stream back-to-back beats after a fixed latency.
//
// Handshake: a write beat transfers in any WRITE cycle where
// bus_dataValid_i=1 and bus_busy_o=0. A beat offered while busy is held by
// the master. Read beats are pushed one per cycle while bus_dataValid_o=1,
// with no backpressure. Only the master's bus_endTransaction_i can stop a
// read early.
module burst_mem_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MEM_WORDS    = 65536,
    parameter int          READ_LATENCY = 2,
    parameter int          BUSY_PERIOD  = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] bus_addrData_i,
    input  logic [3:0]  bus_byteEnables_i,
    input  logic [7:0]  bus_burstSize_i,
    input  logic        bus_readNWrite_i,
    input  logic        bus_beginTransaction_i,
    input  logic        bus_endTransaction_i,
    input  logic        bus_dataValid_i,
    output logic [31:0] bus_addrData_o,
    output logic        bus_endTransaction_o,
    output logic        bus_dataValid_o,
    output logic        bus_busy_o,
    output logic        bus_error_o,
    output logic [2:0]  debug_state
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] WIN_BYTES = 33'(64'(MEM_WORDS) * 64'd4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_WAIT,
        S_READ,
        S_READ_END,
        S_ERROR
    } state_t;

    state_t state, next_state;

    logic [AW-1:0] addr;        // word address of the current beat
    logic [8:0]    beats_left;  // beats still to transfer, 1..256
    logic [3:0]    be_q;        // lane enables latched at begin
    logic [3:0]    wait_left;   // remaining READ_WAIT cycles
    logic [15:0]   busy_cnt;    // WRITE cycle number modulo BUSY_PERIOD

    logic [32:0]   offset;
    logic          in_range;
    logic [AW-1:0] begin_word;
    logic          busy_hit;
    logic          accept;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [31:0]   mem [MEM_WORDS];

    // A 33-bit subtraction keeps addresses below BASE_ADDR negative, so they
    // are rejected instead of wrapping into the window.
    assign offset     = {1'b0, bus_addrData_i} - {1'b0, BASE_ADDR};
    assign in_range   = !offset[32] && (offset < WIN_BYTES);
    assign begin_word = offset[AW+1:2];
    assign start      = (state == S_IDLE) && bus_beginTransaction_i;

    assign busy_hit = (BUSY_PERIOD > 0) && (state == S_WRITE) &&
                      (busy_cnt == 16'(BUSY_PERIOD));
    assign accept   = (state == S_WRITE) && bus_dataValid_i && !busy_hit;

    // State register. Asynchronous reset aborts any burst immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Begin is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus_beginTransaction_i) begin
                    if (!in_range) begin
                        next_state = S_ERROR;
                    end else if (!bus_readNWrite_i) begin
                        next_state = S_WRITE;
                    end else if (READ_LATENCY == 1) begin
                        next_state = S_READ;
                    end else begin
                        next_state = S_READ_WAIT;
                    end
                end
            end
            S_WRITE: begin
                if (bus_endTransaction_i || (accept && beats_left == 9'd1)) begin
                    next_state = S_IDLE;
                end
            end
            S_READ_WAIT: begin
                if (bus_endTransaction_i) begin
                    next_state = S_IDLE;
                end else if (wait_left == 4'd1) begin
                    next_state = S_READ;
                end
            end
            S_READ: begin
                if (bus_endTransaction_i) begin
                    next_state = S_IDLE;
                end else if (beats_left == 9'd1) begin
                    next_state = S_READ_END;
                end
            end
            S_READ_END: next_state = S_IDLE;
            S_ERROR:    next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Burst bookkeeping: latch the transaction at begin, then step the
    // address and beat count per transferred beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr       <= '0;
            beats_left <= '0;
            be_q       <= '0;
            wait_left  <= '0;
            busy_cnt   <= '0;
        end else if (start) begin
            addr       <= begin_word;
            beats_left <= {1'b0, bus_burstSize_i} + 9'd1;
            be_q       <= bus_byteEnables_i;
            wait_left  <= 4'(READ_LATENCY - 1);
            busy_cnt   <= 16'd1;
        end else begin
            case (state)
                S_WRITE: begin
                    busy_cnt <= busy_hit ? 16'd1 : busy_cnt + 16'd1;
                    if (accept) begin
                        addr       <= addr + AW'(1);
                        beats_left <= beats_left - 9'd1;
                    end
                end
                S_READ_WAIT: wait_left <= wait_left - 4'd1;
                S_READ: begin
                    addr       <= addr + AW'(1);
                    beats_left <= beats_left - 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Read address is one beat ahead of what is on the bus, because the RAM
    // output is registered: the begin edge fetches the first word, READ
    // fetches the next word.
    always_comb begin
        rd_addr = addr;
        if (state == S_IDLE) begin
            rd_addr = begin_word;
        end else if (state == S_READ) begin
            rd_addr = addr + AW'(1);
        end
    end

    // RAM array with byte-lane writes and a registered read port. It has no
    // reset, so its contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr][8*i +: 8] <= bus_addrData_i[8*i +: 8];
                end
            end
        end
        rd_data <= mem[rd_addr];
    end

    assign bus_dataValid_o      = (state == S_READ);
    assign bus_addrData_o       = bus_dataValid_o ? rd_data : 32'h0;
    assign bus_endTransaction_o = (state == S_READ_END) || (state == S_ERROR);
    assign bus_error_o          = (state == S_ERROR);
    assign bus_busy_o           = busy_hit;
    assign debug_state          = state;

endmodule
